// File: rtl/fetch_exception_sequencer_pkg.sv
// fetch_exception_sequencer_pkg: shared vectors, PC increment and privilege state encoding
package fetch_exception_sequencer_pkg;
  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] ILL_VEC = 32'h8000_0004;
  localparam logic [31:0] IRQ_VEC = 32'h8000_0008;
  localparam logic [31:0] PC_INC = 32'd4;
  typedef enum logic [1:0] {S_BOOT, S_KERNEL, S_HOLDOFF, S_USER} state_t;
endpackage

// File: rtl/fetch_exception_sequencer_if.sv
// fetch_exception_sequencer_if: pipeline-side handshake bundle of the fetch/exception sequencer
interface fetch_exception_sequencer_if;
  logic stall;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  logic ill_op;
  logic [31:0] ill_pc;
  logic irq_in;
  logic [31:0] pc;
  logic [30:0] rom_addr;
  logic kernel;
  logic exc_take;
  logic [31:0] exc_epc;
  logic flush_ifid;
  logic irq_ack;
  modport master (
    output stall, redirect_valid, redirect_pc, ill_op, ill_pc, irq_in,
    input pc, rom_addr, kernel, exc_take, exc_epc, flush_ifid, irq_ack
  );
  modport slave (
    input stall, redirect_valid, redirect_pc, ill_op, ill_pc, irq_in,
    output pc, rom_addr, kernel, exc_take, exc_epc, flush_ifid, irq_ack
  );
endinterface

// File: rtl/fetch_exception_sequencer_irq_gate.sv
// fetch_exception_sequencer_irq_gate: irq synchroniser, privilege FSM and user-mode hold-off window
module fetch_exception_sequencer_irq_gate
  import fetch_exception_sequencer_pkg::*;
#(
  parameter int HOLDOFF = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic i_irq,
  input  logic i_exc,
  input  logic i_nxt_kernel,
  output logic o_irq_req
);
  state_t r_state;
  logic r_irq_sync;
  logic [3:0] r_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_BOOT;
      r_irq_sync <= 1'b0;
      r_cnt <= 4'd0;
    end else begin
      r_irq_sync <= i_irq;
      case (r_state)
        S_BOOT: r_state <= S_KERNEL;
        S_KERNEL: if (!i_exc && !i_nxt_kernel) begin
          r_state <= S_HOLDOFF;
          r_cnt <= 4'(HOLDOFF);
        end
        S_HOLDOFF: begin
          r_cnt <= r_cnt - 4'd1;
          r_state <= i_exc ? S_KERNEL : (r_cnt == 4'd1) ? S_USER : S_HOLDOFF;
        end
        default: if (i_exc) r_state <= S_KERNEL;
      endcase
    end
  end
  assign o_irq_req = r_irq_sync & (r_state == S_USER);
endmodule

// File: rtl/fetch_exception_sequencer.sv
// fetch_exception_sequencer: next-PC arbitration, exception vectoring and $k0/flush pulse generation
module fetch_exception_sequencer
  import fetch_exception_sequencer_pkg::*;
#(
  parameter int HOLDOFF = 3
) (
  input logic clk,
  input logic reset,
  fetch_exception_sequencer_if.slave bus
);
  logic [31:0] r_pc, r_epc;
  logic r_take, r_ack;
  logic w_irq_req, w_irq_take, w_exc;
  logic [31:0] w_rpc, w_seq, w_nxt;
  assign w_irq_take = w_irq_req & ~bus.stall & ~bus.ill_op;
  assign w_exc = bus.ill_op | w_irq_take;
  // user code may not redirect into kernel space; only exceptions set bit 31
  assign w_rpc = {bus.redirect_pc[31] & r_pc[31], bus.redirect_pc[30:0]};
  assign w_seq = {r_pc[31], r_pc[30:0] + PC_INC[30:0]};
  assign w_nxt = bus.ill_op ? ILL_VEC : w_irq_take ? IRQ_VEC :
                 bus.redirect_valid ? w_rpc : bus.stall ? r_pc : w_seq;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_VEC;
      r_epc <= 32'd0;
      r_take <= 1'b0;
      r_ack <= 1'b0;
    end else begin
      r_pc <= w_nxt;
      r_take <= w_exc;
      r_ack <= w_irq_take;
      if (bus.ill_op) r_epc <= bus.ill_pc + PC_INC;
      else if (w_irq_take) r_epc <= (bus.redirect_valid ? w_rpc : r_pc) + PC_INC;
    end
  end
  fetch_exception_sequencer_irq_gate #(.HOLDOFF(HOLDOFF)) u_gate (
    .clk(clk),
    .reset(reset),
    .i_irq(bus.irq_in),
    .i_exc(w_exc),
    .i_nxt_kernel(w_nxt[31]),
    .o_irq_req(w_irq_req)
  );
  assign bus.pc = r_pc;
  assign bus.rom_addr = r_pc[30:0];
  assign bus.kernel = r_pc[31];
  assign bus.exc_take = r_take;
  assign bus.flush_ifid = r_take;
  assign bus.exc_epc = r_epc;
  assign bus.irq_ack = r_ack;
endmodule

// File: tb/tb_fetch_exception_sequencer.sv
// tb_fetch_exception_sequencer: directed scoreboard bench for the fetch/exception sequencer
module tb_fetch_exception_sequencer;
  typedef struct {
    string tag;
    logic [31:0] pc;
    logic take;
    logic ack;
    logic [31:0] epc;
    logic chk_epc;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  exp_t sb[$];
  fetch_exception_sequencer_if bus();
  fetch_exception_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input bit rst, input bit stl, input bit rv,
                      input logic [31:0] rpc, input bit ill, input logic [31:0] ipc,
                      input bit irq, input logic [31:0] e_pc, input bit e_take,
                      input bit e_ack, input logic [31:0] e_epc, input bit c_epc);
    exp_t e;
    @(negedge clk);
    reset = rst;
    bus.stall = stl;
    bus.redirect_valid = rv;
    bus.redirect_pc = rpc;
    bus.ill_op = ill;
    bus.ill_pc = ipc;
    bus.irq_in = irq;
    sb.push_back('{tag, e_pc, e_take, e_ack, e_epc, c_epc});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".pc"}, bus.pc, e.pc);
    chk({e.tag, ".rom"}, {1'b0, bus.rom_addr}, {1'b0, e.pc[30:0]});
    chk({e.tag, ".kernel"}, {31'd0, bus.kernel}, {31'd0, e.pc[31]});
    chk({e.tag, ".take"}, {31'd0, bus.exc_take}, {31'd0, e.take});
    chk({e.tag, ".flush"}, {31'd0, bus.flush_ifid}, {31'd0, e.take});
    chk({e.tag, ".ack"}, {31'd0, bus.irq_ack}, {31'd0, e.ack});
    if (e.chk_epc) chk({e.tag, ".epc"}, bus.exc_epc, e.epc);
  endtask
  task automatic idle(input string tag, input bit irq, input logic [31:0] e_pc);
    step(tag, 0, 0, 0, 0, 0, 0, irq, e_pc, 0, 0, 0, 0);
  endtask
  task automatic vec(input string tag, input bit irq, input logic [31:0] e_epc);
    step(tag, 0, 0, 0, 0, 0, 0, irq, 32'h8000_0008, 1, 1, e_epc, 1);
  endtask
  // kernel -> user redirect, then the three hold-off cycles; irq_in raised in the last one
  task automatic go_user(input string tag, input logic [31:0] a, input bit irq_last);
    step({tag, ".r"}, 0, 0, 1, a, 0, 0, 0, a, 0, 0, 0, 0);
    idle({tag, ".h1"}, 0, a + 4);
    idle({tag, ".h2"}, 0, a + 8);
    idle({tag, ".h3"}, irq_last, a + 12);
  endtask
  initial begin
    bus.stall = 0;
    bus.redirect_valid = 0;
    bus.redirect_pc = 0;
    bus.ill_op = 0;
    bus.ill_pc = 0;
    bus.irq_in = 0;
    step("rst0", 1, 0, 0, 0, 0, 0, 0, 32'h8000_0000, 0, 0, 0, 1);
    step("rst1", 1, 0, 0, 0, 0, 0, 0, 32'h8000_0000, 0, 0, 0, 1);
    idle("boot0", 0, 32'h8000_0004);
    idle("boot1", 0, 32'h8000_0008);
    step("hold.r", 0, 0, 1, 32'h0000_01AC, 0, 0, 1, 32'h0000_01AC, 0, 0, 0, 0);
    idle("hold.1", 1, 32'h0000_01B0);
    idle("hold.2", 1, 32'h0000_01B4);
    idle("hold.3", 1, 32'h0000_01B8);
    vec("hold.irq", 1, 32'h0000_01BC);
    idle("kidle", 0, 32'h8000_000C);
    go_user("u200", 32'h0000_01F4, 1);
    vec("u200.irq", 1, 32'h0000_0204);
    go_user("u300", 32'h0000_0280, 1);
    step("u300.irq", 0, 0, 1, 32'h0000_0300, 0, 0, 1, 32'h8000_0008, 1, 1, 32'h0000_0304, 1);
    go_user("uill", 32'h0000_0400, 1);
    step("uill.ill", 0, 0, 0, 0, 1, 32'h0000_0120, 1, 32'h8000_0004, 1, 0, 32'h0000_0124, 1);
    idle("uill.k1", 1, 32'h8000_0008);
    idle("uill.k2", 1, 32'h8000_000C);
    go_user("ubit", 32'h0000_0700, 0);
    step("ubit.r", 0, 0, 1, 32'h8000_0600, 0, 0, 0, 32'h0000_0600, 0, 0, 0, 0);
    idle("ubit.seq", 0, 32'h0000_0604);
    step("ubit.ill", 0, 0, 0, 0, 1, 32'h0000_0604, 0, 32'h8000_0004, 1, 0, 32'h0000_0608, 1);
    go_user("ustl", 32'h0000_0500, 1);
    for (int i = 0; i < 3; i++)
      step($sformatf("ustl.s%0d", i), 0, 1, 0, 0, 0, 0, 1, 32'h0000_050C, 0, 0, 0, 0);
    vec("ustl.irq", 1, 32'h0000_0510);
    step("krst", 1, 0, 0, 0, 0, 0, 1, 32'h8000_0000, 0, 0, 0, 1);
    idle("krst.boot", 0, 32'h8000_0004);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
